figure_motion_ctrl: RTL and testbench
=====================================

// Module: figure_motion_ctrl
// PURPOSE
//  Per-frame motion controller for one player figure (fire or water). Samples
//  left/right/jump buttons once per frame and owns the figure's walk and jump
//  physics. Drives rect_posx/rect_posy into the figure drawing stage, so the
//  sprite moves only between frames (no tearing). Instantiated once per figure.
// PARAMETERS
//  FIG_W    52   on-screen figure width in px (26-px sprite drawn at 2x)
//  FIG_H    52   on-screen figure height in px
//  X_MIN    0    leftmost allowed rect_posx
//  X_MAX    1024 right screen edge; rect_posx <= X_MAX-FIG_W
//  Y_MIN    0    ceiling; rect_posy >= Y_MIN
//  FLOOR_Y  700  rect_posy when standing on the floor
//  START_X  100  rect_posx after reset
//  H_STEP   3    px per frame horizontal walk speed
//  JUMP_V   12   initial upward speed (px/frame)
//  GRAVITY  1    speed change per frame
//  V_MAX    12   terminal falling speed (px/frame)
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  vsync      in   1   vsync from timing chain; rising edge = frame tick
//  move_left  in   1   level, already synchronised to clk
//  move_right in   1   level, already synchronised to clk
//  jump       in   1   level, already synchronised to clk
//  rect_posx  out  12  figure top-left x, to figure drawing stage
//  rect_posy  out  12  figure top-left y, to figure drawing stage
//  facing     out  1   0 = right, 1 = left (sprite mirroring)
//  airborne   out  1   1 while state != GROUND
// BEHAVIOUR
//  - Reset (sync, active-high) wins over everything, including a same-cycle
//    tick: rect_posx=START_X, rect_posy=FLOOR_Y, facing=0, airborne=0,
//    state=GROUND, vel=0, jump_armed=1, vsync_q=0. A reset mid-jump aborts it.
//  - Tick: vsync_q <= vsync; tick = vsync & ~vsync_q. Registers update only on
//    a tick cycle, so outputs change 1 clk after vsync is first sampled high,
//    exactly once per frame.
//  - Horizontal (per tick): left only -> x -= H_STEP, saturating at X_MIN,
//    facing=1. Right only -> x += H_STEP, saturating at X_MAX-FIG_W,
//    facing=0. Both or neither -> x and facing unchanged. Saturate, never wrap.
//    Horizontal motion is allowed in every vertical state.
//  - jump_armed: cleared when a jump starts, set on any tick with jump=0.
//    Holding jump therefore gives exactly one jump.
//  - FSM (vel is an unsigned 5-bit magnitude, advanced only on ticks):
//    GROUND: jump & jump_armed -> RISE, vel=JUMP_V, jump_armed=0. Else stay.
//    RISE:   if y-vel < Y_MIN (signed compare) -> y=Y_MIN, vel=0, FALL.
//            else y-=vel. Then if vel<=GRAVITY -> vel=0, FALL,
//            else vel-=GRAVITY.
//    FALL:   if y+vel >= FLOOR_Y -> y=FLOOR_Y, vel=0, GROUND.
//            else y+=vel, vel=min(vel+GRAVITY, V_MAX).
//  - Compute vertical arithmetic at 13 bits to catch under- and overflow.
//    rect_posy never leaves [Y_MIN, FLOOR_Y].
//  - airborne is registered. It equals (next state != GROUND) and is valid
//    on the same edge as the positions.
//  - Button changes between ticks are ignored. Only the tick-cycle value counts.
// STRUCTURE
//  - figure_pkg: typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;
//    FIG_SCALE=2, SPRITE_W=26, SPRITE_H=26, BG_COLOR=12'h452.
//    figure_motion_ctrl and the drawing stage share these.
//  - Sub-module frame_tick_gen (vsync rising-edge detector, sync reset).
//    Reused by other per-frame controllers.
//  - Next-state/next-position logic goes in one always_comb. All state sits in
//    one always_ff.
// TESTING
//  - Reset with move_right=1 and vsync toggling -> x=100, y=700, facing=0,
//    airborne=0. No motion until rst=0.
//  - move_right held 400 frames -> x rises 3/frame and saturates at 972,
//    never 973+. Then move_left 1 frame -> x=969, facing=1.
//  - jump pulse 1 frame -> y sequence 688,677,667,... peaks at 622. Falls
//    back to exactly 700 with airborne low on landing. Total airborne frames
//    match the model.
//  - jump held 60 frames -> exactly one jump. Release 1 frame, press again ->
//    second jump starts on that tick.
//  - Y_MIN=650, jump -> y clamps to 650, FALL from vel 0, lands at 700.
//    Both left and right held during this -> x unchanged.
//  - rst asserted mid-RISE on a tick cycle -> next cycle: reset values,
//    state GROUND. vsync held high for many cycles -> only one update.

Source files
------------

// File: rtl/figure_pkg.sv
// Types and constants shared by the figure motion controller and the figure drawing stage.
package figure_pkg;

  typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;

  localparam int          FIG_SCALE = 2;
  localparam int          SPRITE_W  = 26;
  localparam int          SPRITE_H  = 26;
  localparam logic [11:0] BG_COLOR  = 12'h452;

  localparam int POS_W  = 12;
  localparam int CALC_W = 13;
  localparam int VEL_W  = 5;

endpackage

// File: rtl/frame_tick_gen.sv
// Vsync rising-edge detector: one-cycle frame tick, synchronous active-high reset.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic i_vsync,
  output logic o_tick
);

  logic r_vsync_q;

  always_ff @(posedge clk) begin
    if (rst) r_vsync_q <= 1'b0;
    else     r_vsync_q <= i_vsync;
  end

  assign o_tick = i_vsync & ~r_vsync_q;

endmodule

// File: rtl/figure_motion_ctrl.sv
// Per-frame walk/jump physics for one player figure; positions change only on frame ticks.
module figure_motion_ctrl
  import figure_pkg::*;
#(
  parameter int FIG_W   = 52,
  parameter int FIG_H   = 52,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 1024,
  parameter int Y_MIN   = 0,
  parameter int FLOOR_Y = 700,
  parameter int START_X = 100,
  parameter int H_STEP  = 3,
  parameter int JUMP_V  = 12,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        jump,
  output logic [11:0] rect_posx,
  output logic [11:0] rect_posy,
  output logic        facing,
  output logic        airborne
);

  localparam logic signed [CALC_W-1:0] C_XMIN  = CALC_W'(X_MIN);
  localparam logic signed [CALC_W-1:0] C_XHI   = CALC_W'(X_MAX - FIG_W);
  localparam logic signed [CALC_W-1:0] C_YMIN  = CALC_W'(Y_MIN);
  localparam logic signed [CALC_W-1:0] C_FLOOR = CALC_W'(FLOOR_Y);
  localparam logic signed [CALC_W-1:0] C_HSTEP = CALC_W'(H_STEP);
  localparam logic [VEL_W-1:0]         C_JV    = VEL_W'(JUMP_V);
  localparam logic [VEL_W-1:0]         C_G     = VEL_W'(GRAVITY);
  localparam logic [VEL_W-1:0]         C_VMAX  = VEL_W'(V_MAX);

  logic                       w_tick;
  motion_state_t              r_state, w_state_nxt;
  logic [VEL_W-1:0]           r_vel, w_vel_nxt;
  logic                       r_armed, w_armed_nxt;
  logic [POS_W-1:0]           w_x_nxt, w_y_nxt;
  logic                       w_face_nxt;
  logic signed [CALC_W-1:0]   w_x13, w_xl, w_xr, w_y13, w_up, w_dn, w_vel13;
  logic [VEL_W:0]             w_vel_inc;

  frame_tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_vsync(vsync),
    .o_tick (w_tick)
  );

  always_comb begin
    w_x13     = signed'({1'b0, rect_posx});
    w_y13     = signed'({1'b0, rect_posy});
    w_vel13   = signed'({{(CALC_W-VEL_W){1'b0}}, r_vel});
    w_xl      = w_x13 - C_HSTEP;
    w_xr      = w_x13 + C_HSTEP;
    w_up      = w_y13 - w_vel13;
    w_dn      = w_y13 + w_vel13;
    w_vel_inc = {1'b0, r_vel} + {1'b0, C_G};

    w_x_nxt     = rect_posx;
    w_y_nxt     = rect_posy;
    w_face_nxt  = facing;
    w_state_nxt = r_state;
    w_vel_nxt   = r_vel;
    w_armed_nxt = r_armed;

    if (w_tick) begin
      if (move_left && !move_right) begin
        w_x_nxt    = (w_xl < C_XMIN) ? C_XMIN[POS_W-1:0] : w_xl[POS_W-1:0];
        w_face_nxt = 1'b1;
      end else if (move_right && !move_left) begin
        w_x_nxt    = (w_xr > C_XHI) ? C_XHI[POS_W-1:0] : w_xr[POS_W-1:0];
        w_face_nxt = 1'b0;
      end

      unique case (r_state)
        GROUND: begin
          if (jump && r_armed) begin
            w_state_nxt = RISE;
            w_vel_nxt   = C_JV;
            w_armed_nxt = 1'b0;
          end
        end
        RISE: begin
          // Ceiling clamp zeroes vel, so the gravity test below also lands in FALL.
          if (w_up < C_YMIN) w_y_nxt = C_YMIN[POS_W-1:0];
          else               w_y_nxt = w_up[POS_W-1:0];
          if (w_up < C_YMIN || r_vel <= C_G) begin
            w_vel_nxt   = '0;
            w_state_nxt = FALL;
          end else begin
            w_vel_nxt = r_vel - C_G;
          end
        end
        FALL: begin
          if (w_dn >= C_FLOOR) begin
            w_y_nxt     = C_FLOOR[POS_W-1:0];
            w_vel_nxt   = '0;
            w_state_nxt = GROUND;
          end else begin
            w_y_nxt   = w_dn[POS_W-1:0];
            w_vel_nxt = (w_vel_inc > {1'b0, C_VMAX}) ? C_VMAX : w_vel_inc[VEL_W-1:0];
          end
        end
        default: w_state_nxt = GROUND;
      endcase

      if (!jump) w_armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rect_posx <= POS_W'(START_X);
      rect_posy <= POS_W'(FLOOR_Y);
      facing    <= 1'b0;
      airborne  <= 1'b0;
      r_state   <= GROUND;
      r_vel     <= '0;
      r_armed   <= 1'b1;
    end else begin
      rect_posx <= w_x_nxt;
      rect_posy <= w_y_nxt;
      facing    <= w_face_nxt;
      airborne  <= (w_state_nxt != GROUND);
      r_state   <= w_state_nxt;
      r_vel     <= w_vel_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

endmodule

// File: tb/tb_figure_motion_ctrl.sv
// Randomised and directed bench for figure_motion_ctrl against a per-frame physics model.
module tb_figure_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b0;
  logic move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
  logic [11:0] px [2];
  logic [11:0] py [2];
  logic        fc [2];
  logic        ab [2];

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0 = standing, 1 = going up, 2 = coming down
  int mx [2], my [2], mv [2], mph [2];
  bit marm [2], mface [2];
  int ymin [2] = '{0, 650};

  always #5 clk = ~clk;

  figure_motion_ctrl u_dut0 (
    .clk(clk), .rst(rst), .vsync(vsync), .move_left(move_left), .move_right(move_right),
    .jump(jump), .rect_posx(px[0]), .rect_posy(py[0]), .facing(fc[0]), .airborne(ab[0])
  );

  figure_motion_ctrl #(.Y_MIN(650)) u_dut1 (
    .clk(clk), .rst(rst), .vsync(vsync), .move_left(move_left), .move_right(move_right),
    .jump(jump), .rect_posx(px[1]), .rect_posy(py[1]), .facing(fc[1]), .airborne(ab[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 100; my[k] = 700; mv[k] = 0; mph[k] = 0; marm[k] = 1'b1; mface[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit l, input bit r, input bit j);
    for (int k = 0; k < 2; k++) begin
      if (l && !r) begin
        mx[k] = (mx[k] - 3 < 0) ? 0 : mx[k] - 3;
        mface[k] = 1'b1;
      end else if (r && !l) begin
        mx[k] = (mx[k] + 3 > 972) ? 972 : mx[k] + 3;
        mface[k] = 1'b0;
      end
      if (mph[k] == 0) begin
        if (j && marm[k]) begin mph[k] = 1; mv[k] = 12; marm[k] = 1'b0; end
      end else if (mph[k] == 1) begin
        if (my[k] - mv[k] < ymin[k]) begin
          my[k] = ymin[k]; mv[k] = 0; mph[k] = 2;
        end else begin
          my[k] = my[k] - mv[k];
          if (mv[k] <= 1) begin mv[k] = 0; mph[k] = 2; end
          else mv[k] = mv[k] - 1;
        end
      end else begin
        if (my[k] + mv[k] >= 700) begin
          my[k] = 700; mv[k] = 0; mph[k] = 0;
        end else begin
          my[k] = my[k] + mv[k];
          mv[k] = (mv[k] + 1 > 12) ? 12 : mv[k] + 1;
        end
      end
      if (!j) marm[k] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("%s%0d_x", tag, k), 32'(px[k]), 32'(mx[k]));
      check_val($sformatf("%s%0d_y", tag, k), 32'(py[k]), 32'(my[k]));
      check_val($sformatf("%s%0d_facing", tag, k), 32'(fc[k]), 32'(mface[k]));
      check_val($sformatf("%s%0d_airborne", tag, k), 32'(ab[k]), 32'(mph[k] != 0));
    end
  endtask

  // One frame: buttons valid at the tick, scrambled between ticks (must be ignored).
  task automatic frame(input bit l, input bit r, input bit j, input int hold);
    @(negedge clk);
    vsync = 1'b1; move_left = l; move_right = r; jump = j;
    @(posedge clk); #1;
    model_step(l, r, j);
    check_all("tick");
    repeat (hold) begin
      @(negedge clk);
      move_left = 1'($urandom); move_right = 1'($urandom); jump = 1'($urandom);
    end
    @(negedge clk);
    vsync = 1'b0;
    repeat (2) begin
      @(negedge clk);
      move_left = 1'($urandom); move_right = 1'($urandom); jump = 1'($urandom);
    end
    check_all("hold");
  endtask

  task automatic land(input int budget);
    int n = 0;
    while ((mph[0] != 0 || mph[1] != 0) && n < budget) begin
      frame(1'b0, 1'b0, 1'b0, 1);
      n++;
    end
    check_val("land_budget", 32'(mph[0] != 0 || mph[1] != 0), 32'd0);
  endtask

  initial begin
    int peak, air_dut, air_mod, rises, x_before;
    bit prev_ab;
    int exp_y [3];
    exp_y = '{688, 677, 667};

    // reset holds despite right button and vsync activity
    model_reset();
    move_right = 1'b1;
    repeat (12) begin @(negedge clk); vsync = ~vsync; end
    @(negedge clk); #1;
    check_all("reset");
    rst = 1'b0; vsync = 1'b0; move_right = 1'b0;
    @(negedge clk);
    check_all("after_rst");

    // right saturation then one step left
    for (int i = 0; i < 400; i++) frame(1'b0, 1'b1, 1'b0, 1);
    check_val("x_sat", 32'(px[0]), 32'd972);
    frame(1'b1, 1'b0, 1'b0, 1);
    check_val("x_left", 32'(px[0]), 32'd969);
    check_val("face_left", 32'(fc[0]), 32'd1);

    // single jump pulse
    frame(1'b0, 1'b0, 1'b1, 2);
    check_val("jump_start_y", 32'(py[0]), 32'd700);
    peak = 700; air_dut = 1; air_mod = 1;
    for (int i = 0; i < 80 && mph[0] != 0; i++) begin
      frame(1'b0, 1'b0, 1'b0, 2);
      if (i < 3) check_val($sformatf("rise_y%0d", i), 32'(py[0]), 32'(exp_y[i]));
      if (int'(py[0]) < peak) peak = int'(py[0]);
      if (ab[0]) air_dut++;
      if (mph[0] != 0) air_mod++;
    end
    check_val("peak", 32'(peak), 32'd622);
    check_val("landed_y", 32'(py[0]), 32'd700);
    check_val("landed_air", 32'(ab[0]), 32'd0);
    check_val("air_frames", 32'(air_dut), 32'(air_mod));
    land(40);

    // held jump gives one jump; re-press after release jumps on that tick
    rises = 0; prev_ab = 1'b0;
    for (int i = 0; i < 60; i++) begin
      frame(1'b0, 1'b0, 1'b1, 1);
      if (ab[0] && !prev_ab) rises++;
      prev_ab = ab[0];
    end
    check_val("held_jumps", 32'(rises), 32'd1);
    frame(1'b0, 1'b0, 1'b0, 1);
    frame(1'b0, 1'b0, 1'b1, 1);
    check_val("rejump", 32'(ab[0]), 32'd1);
    land(60);

    // low ceiling on instance 1, both directions held
    x_before = int'(px[1]);
    frame(1'b1, 1'b1, 1'b1, 1);
    peak = 700;
    for (int i = 0; i < 40; i++) begin
      frame(1'b1, 1'b1, 1'b0, 1);
      if (int'(py[1]) < peak) peak = int'(py[1]);
    end
    check_val("ceil_peak", 32'(peak), 32'd650);
    check_val("ceil_land", 32'(py[1]), 32'd700);
    check_val("both_x", 32'(px[1]), 32'(x_before));

    // random frames
    for (int i = 0; i < 300; i++)
      frame(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
    land(60);

    // reset on a tick cycle during the rise
    frame(1'b0, 1'b1, 1'b1, 1);
    repeat (3) frame(1'b0, 1'b1, 1'b0, 1);
    check_val("pre_rst_air", 32'(ab[0]), 32'd1);
    @(negedge clk);
    vsync = 1'b1; rst = 1'b1; move_right = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0; vsync = 1'b0;
    @(negedge clk);

    // long vsync high must still give a single update
    frame(1'b0, 1'b1, 1'b0, 50);
    check_val("long_vsync_x", 32'(px[0]), 32'd103);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
